wb_mailbox_array: RTL
=====================

WB_MAILBOX_ARRAY -- requirements
Module: wb_mailbox_array

Interface
REQ-001 Parameter CHANNELS, default 2, number of independent mailbox channels, legal range 1..8.
REQ-002 Parameter DEPTH, default 4, entries per FIFO, power of two, legal range 2..16.
REQ-003 Parameter DATA_W, default 8, mailbox data width in bits, legal range 1..32.
REQ-004 Port clk  input  1  single clock for all logic.
REQ-005 Port reset_b  input  1  reset; synchronous, active-low.
REQ-006 Ports wb_cyc_in, wb_stb_in, wb_we_in  input  1 each  Wishbone classic cycle, strobe, write-enable.
REQ-007 Port wb_addr_in  input  32  byte address; only bits [7:2] decoded.
REQ-008 Port wb_data_in  input  32  write data.
REQ-009 Port wb_ack_out  output  1  Wishbone acknowledge.
REQ-010 Port wb_data_out  output  32  read data.
REQ-011 Port tx_data_out  output  CHANNELS*DATA_W  host-to-device data; channel n at bits [n*DATA_W +: DATA_W].
REQ-012 Ports tx_valid_out, tx_ready_in  output, input  CHANNELS each  host-to-device handshake, per channel.
REQ-013 Port rx_data_in  input  CHANNELS*DATA_W  device-to-host data; packed as tx_data_out.
REQ-014 Ports rx_valid_in, rx_ready_out  input, output  CHANNELS each  device-to-host handshake, per channel.
REQ-015 Port irq_out  output  1  level interrupt to host.

Function
REQ-016 Each channel SHALL contain one TX FIFO (host writes, device drains) and one RX FIFO (device fills, host reads), each DEPTH x DATA_W, count width clog2(DEPTH)+1.
REQ-017 Decode: channel = wb_addr_in[7:4], register = wb_addr_in[3:2]; 0 DATA, 1 STATUS, 2 IRQ_EN, 3 reserved.
REQ-018 Channel index >= CHANNELS or reserved register: writes ignored, reads return 0, ack still generated.
REQ-019 Ack: wb_ack_out SHALL assert exactly one cycle after the first cycle with wb_cyc_in & wb_stb_in & !wb_ack_out, for one cycle only; every access therefore takes 2 cycles, and the side effect occurs once, on the ack cycle.
REQ-020 wb_data_out SHALL be valid during the ack cycle and 0 otherwise; unused upper bits 0.
REQ-021 DATA write: push wb_data_in[DATA_W-1:0] into TX FIFO; if full, drop data and set sticky TX_OVF.
REQ-022 DATA read: pop RX FIFO head, returned zero-extended; if empty, return 0, no pop, set sticky RX_UNF.
REQ-023 STATUS read bits: [0] RX nonempty, [1] RX full, [2] TX empty, [3] TX full, [4] TX_OVF, [5] RX_UNF, [12:8] RX count, [20:16] TX count.
REQ-024 STATUS write: a 1 in bit 4 or bit 5 clears TX_OVF or RX_UNF respectively; other bits ignored.
REQ-025 IRQ_EN bits: [0] RX nonempty, [1] TX empty, [2] error (TX_OVF|RX_UNF); read back as written.
REQ-026 tx_valid_out[n] = TX FIFO n nonempty; tx_data_out lane n = TX head; pop when tx_valid_out & tx_ready_in.
REQ-027 rx_ready_out[n] = RX FIFO n not full; push rx_data_in lane n when rx_valid_in & rx_ready_out.
REQ-028 Simultaneous push and pop on the same FIFO in one cycle SHALL both occur, count unchanged; on a full FIFO the pop frees space only from the next cycle (ready/full use registered count).
REQ-029 FIFO pointers SHALL wrap modulo DEPTH with no lost or duplicated entries.
REQ-030 irq_out SHALL be registered, one cycle after the enabled condition: OR over channels of (en[0]&RXnonempty | en[1]&TXempty | en[2]&(TX_OVF|RX_UNF)).

Reset
REQ-031 On clk edge with reset_b=0: all FIFOs empty, pointers 0, TX_OVF/RX_UNF 0, IRQ_EN 0, wb_ack_out 0, wb_data_out 0, irq_out 0, tx_valid_out 0, rx_ready_out all 1 from first cycle after reset.
REQ-032 Reset asserted mid-access SHALL abort it: no ack, no FIFO side effect.

Verification
REQ-033 Write 0xA5 to ch0 DATA (addr 0x00), tx_ready_in[0]=0 -> ack 1 cycle later; tx_valid_out[0]=1, lane0=0xA5, STATUS TX count=1.
REQ-034 DEPTH=4: five writes to ch1 DATA (0x10) with tx_ready_in=0 -> STATUS bit3=1, bit4=1, TX count 4; write 0x10 to STATUS clears bit4.
REQ-035 Device pushes 0x11,0x22 on ch0, host reads 0x00 three times -> returns 0x11, 0x22, 0; STATUS bit5=1.
REQ-036 IRQ_EN ch1=0x1, device pushes one byte ch1 -> irq_out=1 next cycle; host reads DATA -> irq_out=0 one cycle after ack.
REQ-037 Full RX ch0 with rx_valid_in held and host reading continuously -> exactly DEPTH+reads entries accepted, order preserved across pointer wrap.
REQ-038 Access to addr 0xF0 (ch15, absent) -> ack in 1 cycle, read 0, no state change; reset_b low during stb -> no ack.

Source files
------------

// File: rtl/wb_mailbox_array.sv
// rtl/wb_mailbox_array.sv - Wishbone-mapped array of per-channel TX/RX mailbox FIFOs
// Host pushes TX / pops RX over Wishbone; device side uses valid/ready per channel.
module wb_mailbox_array #(
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 4,
    parameter int DATA_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset_b,
    input  logic                       wb_cyc_in,
    input  logic                       wb_stb_in,
    input  logic                       wb_we_in,
    input  logic [31:0]                wb_addr_in,
    input  logic [31:0]                wb_data_in,
    output logic                       wb_ack_out,
    output logic [31:0]                wb_data_out,
    output logic [CHANNELS*DATA_W-1:0] tx_data_out,
    output logic [CHANNELS-1:0]        tx_valid_out,
    input  logic [CHANNELS-1:0]        tx_ready_in,
    input  logic [CHANNELS*DATA_W-1:0] rx_data_in,
    input  logic [CHANNELS-1:0]        rx_valid_in,
    output logic [CHANNELS-1:0]        rx_ready_out,
    output logic                       irq_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_tx_mem [CHANNELS][DEPTH];
    logic [DATA_W-1:0] r_rx_mem [CHANNELS][DEPTH];
    logic [AW-1:0]     r_tx_wp  [CHANNELS];
    logic [AW-1:0]     r_tx_rp  [CHANNELS];
    logic [AW-1:0]     r_rx_wp  [CHANNELS];
    logic [AW-1:0]     r_rx_rp  [CHANNELS];
    logic [CW-1:0]     r_tx_cnt [CHANNELS];
    logic [CW-1:0]     r_rx_cnt [CHANNELS];
    logic [2:0]        r_irq_en [CHANNELS];
    logic [CHANNELS-1:0] r_tx_ovf, r_rx_unf;
    logic              r_ack, r_irq;
    logic [31:0]       r_rdata;

    logic              w_req;
    logic [3:0]        w_ch;
    logic [1:0]        w_reg;
    logic [31:0]       w_rd_data;
    logic              w_irq_next;
    logic [CHANNELS-1:0] w_sel, w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic [CHANNELS-1:0] w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
    logic              w_unused;

    assign w_req    = wb_cyc_in & wb_stb_in & ~r_ack;
    assign w_ch     = wb_addr_in[7:4];
    assign w_reg    = wb_addr_in[3:2];
    assign w_unused = ^{wb_addr_in[31:8], wb_addr_in[1:0], wb_data_in};

    assign wb_ack_out  = r_ack;
    assign wb_data_out = r_rdata;
    assign irq_out     = r_irq;

    // Absent channels never match the loop index, so they decode to nothing.
    always_comb begin
        w_rd_data    = '0;
        w_irq_next   = 1'b0;
        w_sel        = '0;
        w_tx_push    = '0;
        w_tx_pop     = '0;
        w_rx_push    = '0;
        w_rx_pop     = '0;
        w_tx_empty   = '0;
        w_tx_full    = '0;
        w_rx_empty   = '0;
        w_rx_full    = '0;
        tx_valid_out = '0;
        rx_ready_out = '0;
        tx_data_out  = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            w_tx_empty[n] = (r_tx_cnt[n] == '0);
            w_tx_full[n]  = (r_tx_cnt[n] == CW'(DEPTH));
            w_rx_empty[n] = (r_rx_cnt[n] == '0);
            w_rx_full[n]  = (r_rx_cnt[n] == CW'(DEPTH));
            w_sel[n]      = w_req && (w_reg != 2'd3) && (w_ch == 4'(n));
            w_tx_push[n]  = w_sel[n] && wb_we_in && (w_reg == 2'd0) && !w_tx_full[n];
            w_tx_pop[n]   = !w_tx_empty[n] && tx_ready_in[n];
            w_rx_push[n]  = !w_rx_full[n] && rx_valid_in[n];
            w_rx_pop[n]   = w_sel[n] && !wb_we_in && (w_reg == 2'd0) && !w_rx_empty[n];
            tx_valid_out[n] = !w_tx_empty[n];
            rx_ready_out[n] = !w_rx_full[n];
            tx_data_out[n*DATA_W +: DATA_W] = r_tx_mem[n][r_tx_rp[n]];
            w_irq_next = w_irq_next
                       | (r_irq_en[n][0] & ~w_rx_empty[n])
                       | (r_irq_en[n][1] & w_tx_empty[n])
                       | (r_irq_en[n][2] & (r_tx_ovf[n] | r_rx_unf[n]));
            if (w_ch == 4'(n)) begin
                case (w_reg)
                    2'd0: if (!w_rx_empty[n]) w_rd_data[DATA_W-1:0] = r_rx_mem[n][r_rx_rp[n]];
                    2'd1: begin
                        w_rd_data[0]       = ~w_rx_empty[n];
                        w_rd_data[1]       = w_rx_full[n];
                        w_rd_data[2]       = w_tx_empty[n];
                        w_rd_data[3]       = w_tx_full[n];
                        w_rd_data[4]       = r_tx_ovf[n];
                        w_rd_data[5]       = r_rx_unf[n];
                        w_rd_data[8 +: CW]  = r_rx_cnt[n];
                        w_rd_data[16 +: CW] = r_tx_cnt[n];
                    end
                    2'd2: w_rd_data[2:0] = r_irq_en[n];
                    default: w_rd_data = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            r_ack    <= 1'b0;
            r_rdata  <= '0;
            r_irq    <= 1'b0;
            r_tx_ovf <= '0;
            r_rx_unf <= '0;
            for (int n = 0; n < CHANNELS; n++) begin
                r_tx_wp[n]  <= '0;
                r_tx_rp[n]  <= '0;
                r_rx_wp[n]  <= '0;
                r_rx_rp[n]  <= '0;
                r_tx_cnt[n] <= '0;
                r_rx_cnt[n] <= '0;
                r_irq_en[n] <= '0;
            end
        end else begin
            r_ack   <= w_req;
            r_rdata <= (w_req && !wb_we_in) ? w_rd_data : 32'd0;
            r_irq   <= w_irq_next;
            for (int n = 0; n < CHANNELS; n++) begin
                if (w_tx_push[n]) r_tx_wp[n] <= r_tx_wp[n] + AW'(1);
                if (w_tx_pop[n])  r_tx_rp[n] <= r_tx_rp[n] + AW'(1);
                if (w_rx_push[n]) r_rx_wp[n] <= r_rx_wp[n] + AW'(1);
                if (w_rx_pop[n])  r_rx_rp[n] <= r_rx_rp[n] + AW'(1);
                r_tx_cnt[n] <= r_tx_cnt[n] + CW'(w_tx_push[n]) - CW'(w_tx_pop[n]);
                r_rx_cnt[n] <= r_rx_cnt[n] + CW'(w_rx_push[n]) - CW'(w_rx_pop[n]);
                if (w_sel[n] && wb_we_in) begin
                    if (w_reg == 2'd0 && w_tx_full[n]) r_tx_ovf[n] <= 1'b1;
                    if (w_reg == 2'd1) begin
                        if (wb_data_in[4]) r_tx_ovf[n] <= 1'b0;
                        if (wb_data_in[5]) r_rx_unf[n] <= 1'b0;
                    end
                    if (w_reg == 2'd2) r_irq_en[n] <= wb_data_in[2:0];
                end
                if (w_sel[n] && !wb_we_in && w_reg == 2'd0 && w_rx_empty[n]) r_rx_unf[n] <= 1'b1;
            end
        end
    end

    // Storage needs no reset: only entries between the pointers are ever observed.
    always_ff @(posedge clk) begin
        for (int n = 0; n < CHANNELS; n++) begin
            if (w_tx_push[n]) r_tx_mem[n][r_tx_wp[n]] <= wb_data_in[DATA_W-1:0];
            if (w_rx_push[n]) r_rx_mem[n][r_rx_wp[n]] <= rx_data_in[n*DATA_W +: DATA_W];
        end
    end
endmodule
